// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-segment 7-segment display.
// Walks the digits through a BLANK gap and then a SHOW window. It drives one
// shared BCD decoder plus one-hot digit enables. A new digit word is only
// captured at the frame boundary, so a frame never mixes old and new digits.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_req,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      lz_suppress,
  output logic                      load_ack,
  output logic                      frame_tick,
  output logic [3:0]                bcd_out,
  output logic [NUM_DIGITS-1:0]     digit_en
);

  // One counter serves both phases, so size it for the longer of the two.
  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         digit_idx_q, digit_idx_d;
  logic [CNT_W-1:0]         div_cnt_q, div_cnt_d;
  logic [4*NUM_DIGITS-1:0]  shadow_q, shadow_d;
  logic                     boundary;

  logic [NUM_DIGITS-1:0]    digit_en_q;
  logic [3:0]               bcd_out_q;
  logic                     load_ack_q;
  logic                     frame_tick_q;

  // Phase sequencing and capture of the displayed word at the frame boundary.
  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    div_cnt_d   = div_cnt_q;
    shadow_d    = shadow_q;
    boundary    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (div_cnt_q == BLANK_LAST) begin
          state_d   = ST_SHOW;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      ST_SHOW: begin
        if (div_cnt_q == SHOW_LAST) begin
          state_d   = ST_BLANK;
          div_cnt_d = '0;
          if (digit_idx_q == IDX_LAST) begin
            digit_idx_d = '0;
            boundary    = 1'b1;
          end else begin
            digit_idx_d = digit_idx_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // A request is serviced only if it is still present on the boundary edge.
    if (boundary && load_req) begin
      shadow_d = value;
    end
  end

  // Build the display code from the word that will be shown next cycle.
  // This way the first BLANK after a capture already presents the new digit 0.
  logic [3:0]            digit_arr [NUM_DIGITS];
  logic [NUM_DIGITS:0]   zero_from;
  logic [NUM_DIGITS-1:0] suppress_vec;
  logic [NUM_DIGITS-1:0] onehot_d;
  logic [3:0]            code_d;

  assign zero_from[NUM_DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit_arr[gi] = shadow_d[4*gi +: 4];
      // zero_from[i]: digits i..NUM_DIGITS-1 are all zero.
      assign zero_from[gi] = (shadow_d[4*gi +: 4] == 4'h0) && zero_from[gi+1];
      if (gi == 0) begin : g_lsd
        // The least significant digit always shows, so a zero value reads "0".
        assign suppress_vec[gi] = 1'b0;
      end else begin : g_upper
        assign suppress_vec[gi] = lz_suppress && zero_from[gi];
      end
    end
  endgenerate

  assign code_d   = suppress_vec[digit_idx_d] ? 4'hF : digit_arr[digit_idx_d];
  assign onehot_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx_d;

  // State registers and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_BLANK;
      digit_idx_q  <= '0;
      div_cnt_q    <= '0;
      shadow_q     <= '0;
      digit_en_q   <= '0;
      bcd_out_q    <= 4'hF;
      load_ack_q   <= 1'b0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      digit_idx_q  <= digit_idx_d;
      div_cnt_q    <= div_cnt_d;
      shadow_q     <= shadow_d;
      digit_en_q   <= (state_d == ST_SHOW) ? onehot_d : '0;
      bcd_out_q    <= code_d;
      load_ack_q   <= boundary && load_req;
      frame_tick_q <= boundary;
    end
  end

  assign digit_en   = digit_en_q;
  assign bcd_out    = bcd_out_q;
  assign load_ack   = load_ack_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: a cycle model pushes the expected outputs on
// every rising edge, and a monitor pops and compares them on the falling edge.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BC    = 1;
  localparam int FRAME = ND * (BC + RD);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load_req = 1'b0;
  logic [4*ND-1:0]  value = '0;
  logic             lz_suppress = 1'b0;
  logic             load_ack;
  logic             frame_tick;
  logic [3:0]       bcd_out;
  logic [ND-1:0]    digit_en;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load_req   (load_req),
    .value      (value),
    .lz_suppress(lz_suppress),
    .load_ack   (load_ack),
    .frame_tick (frame_tick),
    .bcd_out    (bcd_out),
    .digit_en   (digit_en)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ND-1:0] en;
    logic [3:0]    bcd;
    logic          ack;
    logic          tick;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned vectors = 0;
  int unsigned errors  = 0;
  int unsigned ack_cnt = 0;
  int          m_pos   = 0;
  logic [4*ND-1:0] m_shadow = '0;
  bit          started = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Reference display code: a digit is blank when everything from it upward is zero.
  function automatic logic [3:0] ref_code(input logic [4*ND-1:0] sh, input int d, input logic lz);
    logic [4*ND-1:0] upper;
    upper = sh >> (4 * d);
    if (d > 0 && lz && upper == '0) return 4'hF;
    return upper[3:0];
  endfunction

  // Cycle model: track the position inside the frame and predict the outputs.
  always @(posedge clk) begin
    exp_t e;
    int d, ph;
    if (rst) begin
      started  = 1'b1;
      m_pos    = 0;
      m_shadow = '0;
      e.en = '0; e.bcd = 4'hF; e.ack = 1'b0; e.tick = 1'b0;
      sb_q.push_back(e);
    end else if (started) begin
      e.ack = 1'b0; e.tick = 1'b0;
      if (m_pos == FRAME - 1) begin
        e.tick = 1'b1;
        if (load_req) begin
          m_shadow = value;
          e.ack    = 1'b1;
        end
        m_pos = 0;
      end else begin
        m_pos++;
      end
      d  = m_pos / (BC + RD);
      ph = m_pos % (BC + RD);
      e.en  = (ph < BC) ? '0 : (ND'(1) << d);
      e.bcd = ref_code(m_shadow, d, lz_suppress);
      sb_q.push_back(e);
    end
  end

  // Monitor: compare the DUT against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("digit_en",   32'(digit_en),   32'(e.en));
      chk("bcd_out",    32'(bcd_out),    32'(e.bcd));
      chk("load_ack",   32'(load_ack),   32'(e.ack));
      chk("frame_tick", 32'(frame_tick), 32'(e.tick));
    end
  end

  always @(posedge clk) begin
    if (load_ack === 1'b1) ack_cnt++;
  end

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while (m_pos != p && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3 * FRAME) chk("wait_pos_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    @(negedge clk);
    while (load_ack !== 1'b1 && n < 3 * FRAME) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3 * FRAME) chk("ack_timeout", 32'd0, 32'd1);
    else $display("load 0x%h acked at t=%0t", value, $time);
  endtask

  task automatic do_load(input logic [4*ND-1:0] v);
    load_req = 1'b1;
    value    = v;
    wait_ack();
    load_req = 1'b0;
  endtask

  initial begin
    int unsigned a0;
    // 1: reset and free-running scan of an all-zero word
    run_cycles(2);
    rst = 1'b0;
    run_cycles(2 * FRAME);

    // 2: request raised mid-frame, served once at the boundary
    wait_pos(7);
    a0 = ack_cnt;
    do_load(16'h1234);
    run_cycles(FRAME + 3);
    chk("single_ack_1234", 32'(ack_cnt - a0), 32'd1);

    // 3: leading-zero suppression patterns
    lz_suppress = 1'b1;
    do_load(16'h0070);
    run_cycles(FRAME);
    do_load(16'h0000);
    run_cycles(FRAME);
    do_load(16'h0100);
    run_cycles(FRAME);
    lz_suppress = 1'b0;

    // 4a: request withdrawn three clocks before the boundary
    wait_pos(5);
    a0 = ack_cnt;
    load_req = 1'b1;
    value    = 16'hABCD;
    wait_pos(FRAME - 3);
    load_req = 1'b0;
    run_cycles(FRAME + 5);
    chk("withdrawn_no_ack", 32'(ack_cnt - a0), 32'd0);

    // 4b: value changes while the request is held; the boundary value wins
    wait_pos(3);
    load_req = 1'b1;
    value    = 16'h1111;
    wait_pos(15);
    value    = 16'h2222;
    wait_ack();
    load_req = 1'b0;
    run_cycles(FRAME);

    // 5: reset during digit 2 SHOW with a pending request held through reset
    wait_pos(12);
    load_req = 1'b1;
    value    = 16'h4321;
    rst      = 1'b1;
    run_cycles(1);
    rst      = 1'b0;
    a0 = ack_cnt;
    wait_ack();
    load_req = 1'b0;
    run_cycles(3);
    chk("post_reset_ack", 32'(ack_cnt - a0), 32'd1);
    run_cycles(FRAME);

    // 6: back-to-back requests, one ack per frame
    a0 = ack_cnt;
    load_req = 1'b1;
    value    = 16'h5678;
    wait_ack();
    value    = 16'h9012;
    wait_ack();
    load_req = 1'b0;
    run_cycles(FRAME + 3);
    chk("back_to_back_acks", 32'(ack_cnt - a0), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. It uses one BCD-to-7-segment decoder for all digits: it drives the decoder's 4-bit BCD input and the one-hot digit enables. A load handshake captures the digit word only at frame boundaries, so a frame never mixes old and new digits. Blanking gaps suppress ghosting, and optional leading-zero suppression is applied.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=2)
REFRESH_DIV, 1000, clocks each digit is enabled per frame (>=1)
BLANK_CYCLES, 2, clocks all enables are off before each digit (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
load_req  input  1  request to load value; held with value stable until load_ack
value  input  4*NUM_DIGITS  packed BCD digits; digit 0 = value[3:0] (least significant)
lz_suppress  input  1  1 = blank leading zero digits
load_ack  output  1  one-cycle pulse: value captured
frame_tick  output  1  one-cycle pulse at end of each full frame
bcd_out  output  4  BCD code to the shared decoder; 4'hF = blank
digit_en  output  NUM_DIGITS  one-hot active-high digit enable; bit i = digit i

Behaviour:
- Registers:
  - shadow (4*NUM_DIGITS): displayed word.
  - digit_idx: current digit, 0..NUM_DIGITS-1.
  - div_cnt: phase counter, $clog2-sized.
  - state: BLANK or SHOW.
- Reset values (one edge with rst=1):
  - state=BLANK, digit_idx=0, div_cnt=0, shadow=0.
  - digit_en=0, bcd_out=4'hF, load_ack=0, frame_tick=0.
- BLANK:
  - digit_en=0.
  - bcd_out = display code of digit_idx, so data is stable before enable.
  - Lasts BLANK_CYCLES clocks, then goes to SHOW with div_cnt=0.
- SHOW:
  - digit_en has only bit digit_idx set.
  - bcd_out holds the display code.
  - Lasts REFRESH_DIV clocks. Then digit_idx increments, wrapping NUM_DIGITS-1 -> 0, and state goes to BLANK.
- Frame length: exactly NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) clocks.
- Frame boundary edge: the edge ending SHOW of digit NUM_DIGITS-1. On this edge:
  - frame_tick=1 for the following cycle.
  - If load_req=1: shadow<=value (sampled on this edge) and load_ack=1 for the following cycle. Same cycle as frame_tick.
  - If load_req=0: shadow is unchanged and no ack is issued.
- Handshake rules:
  - The requester may drop load_req before the ack. The request is then withdrawn; no capture, no ack.
  - load_req still high in the cycle after load_ack is a new request, served at the next boundary.
  - At most one ack per frame.
- Display code per digit i, taken from shadow:
  - lz_suppress=1, i>0, and digits i..NUM_DIGITS-1 all zero: code = 4'hF.
  - Otherwise: code = shadow digit i.
  - Digit 0 is never suppressed.
  - lz_suppress is sampled combinationally into the next bcd_out register update.
- Non-BCD digits (10..14) pass through unchanged. The decoder turns every segment off for any code above 9.
- Outputs are registered. There is no combinational path from inputs to outputs.
- rst mid-operation:
  - The next edge forces reset values, including shadow=0, and discards any pending request.
  - Scanning restarts at BLANK of digit 0.
  - A load_req held high through reset is served at the first frame boundary after reset.

Test Plan:
(Common settings for all scenarios: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, frame = 20 clocks.)
1. Reset, then release with lz_suppress=0 -> digit_en=0 for 1 clock; then 4'b0001 for 4 clocks with bcd_out=0; pattern repeats through 0010/0100/1000. frame_tick first pulses 20 clocks after release.
2. load_req=1 with value=16'h1234 asserted mid-frame -> load_ack and frame_tick pulse together exactly once, at the boundary. Next frame shows bcd_out 4,3,2,1 under digit_en 0001,0010,0100,1000. Whenever digit_en=0, bcd_out already equals the next digit.
3. Leading-zero suppression with lz_suppress=1:
   - shadow=16'h0070 -> digits 3,2 show 4'hF; digit 1 shows 7; digit 0 shows 0.
   - shadow=16'h0000 -> digits 3..1 show F; digit 0 shows 0.
   - shadow=16'h0100 -> digit 3 F; digits 2..0 show 1,0,0.
4. load_req raised with 16'hABCD, then dropped 3 clocks before the boundary -> no load_ack, shadow unchanged. In a separate run, value changed while load_req is held -> the value present at the boundary edge is captured.
5. rst pulsed for 1 clock while digit 2 is in SHOW and a load_req is pending -> next cycle digit_en=0, bcd_out=F, shadow=0. Scan restarts at digit 0, and the request is acked at the boundary 20 clocks later.
6. Back-to-back requests: load_req held continuously with 16'h5678 then 16'h9012 -> exactly one ack per frame on consecutive frames; shadow updates only at boundaries.
